fetch_stage: RTL and testbench

- Pipelined instruction-fetch stage; sits directly upstream of the decode (ID) register.
- Generates sequential PCs and issues in-order requests to a handshaked instruction memory.
- Buffers returned instructions in a small prefetch queue and presents them to ID with valid/ready.
- Accepts branch/jump redirects from downstream, flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly in front of the decode register.
// It walks a sequential fetch PC, issues in-order requests to a handshaked
// instruction memory, and parks returned words in a small prefetch queue that
// is presented to decode with a valid/ready handshake. A redirect from
// downstream flushes the queue, restarts fetch at the new PC, and marks every
// response still in flight as stale so it is silently dropped on return.
//
// Parameters
//   RESET_PC     first PC fetched after reset
//   DEPTH        prefetch queue entries; also the cap on outstanding plus
//                buffered fetches (power of two, 2..16)
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   imem_req        fetch request valid
//   imem_addr       fetch address (current fetch PC)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid (in request order, >= 1 cycle after accept)
//   imem_rdata      returned instruction word
//   redirect_valid  taken branch/jump; restart fetch
//   redirect_pc     new fetch PC; bits [1:0] are forced to zero
//   if_valid        queue head valid toward decode
//   if_pc           PC of the head instruction (0 when not valid)
//   if_inst         head instruction word (0 when not valid)
//   id_ready        decode consumes the head this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam ptr_t        PTR_ONE = PW'(1);

  // Architectural state
  logic [31:0] fetch_pc;     // next address to request
  logic [31:0] resp_pc;      // PC belonging to the next kept response
  cnt_t        outstanding;  // accepted but not yet answered
  cnt_t        discard;      // pending responses that belong to a dead path
  cnt_t        count;        // queue occupancy
  ptr_t        head;
  ptr_t        tail;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];

  // Handshake decode
  logic [CW:0] in_flight;
  logic        accept;
  logic        resp;
  logic        drop;
  logic        push;
  logic        pop;
  logic [31:0] redirect_tgt;

  // Masking keeps every redirect_pc bit referenced while clearing [1:0].
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Requests are only allowed while the queue can still absorb every word
  // already in flight, which is what makes overflow impossible.
  assign in_flight = {1'b0, outstanding} + {1'b0, count};
  assign imem_req  = rst_n && !redirect_valid && (in_flight < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  // A response with nothing outstanding is a leftover from before reset.
  assign resp = imem_rvalid && (outstanding != '0);
  assign drop = resp && (discard != '0);

  // A redirect wins over both ends of the queue in the same cycle.
  assign push = resp && !drop && !redirect_valid;
  assign pop  = if_valid && id_ready && !redirect_valid;

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? q_pc[head]   : 32'h0;
  assign if_inst  = if_valid ? q_inst[head] : 32'h0;

  // Control state. Reset is synchronous and takes priority over redirect,
  // issue and response; it also abandons everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      // No request is issued during a redirect, so accept is 0 there.
      outstanding <= outstanding + cnt_t'(accept) - cnt_t'(resp);

      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
        // Everything still outstanding after this cycle's response is stale.
        discard  <= outstanding - cnt_t'(resp);
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (drop) begin
          discard <= discard - cnt_t'(1);
        end
        if (push) begin
          tail    <= tail + PTR_ONE;
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          head <= head + PTR_ONE;
        end
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // NOTE: the queue storage is deliberately left without a reset; an entry is
  // only ever read while count says it was written, so clearing it would just
  // add reset fan-out to a register array for no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= resp_pc;
      q_inst[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage (RESET_PC = 0, DEPTH = 4). Inputs are
// driven on the falling edge and outputs compared 1 ns later. A queue-based
// reference model of the fetch stage and a small in-order memory model with
// random latency run alongside the design. A table of hand-derived vectors
// covers the opening stream, followed by hand-written multi-cycle sequences
// and a randomized phase.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_resp;
  int          m_out;
  int          m_disc;

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    cyc       = 0;
  bit    mem_auto  = 1'b0;
  bit    mem_hold  = 1'b0;
  bit    mem_clear = 1'b1;
  int    mem_lat   = 1;
  int    resp_pct  = 100;
  int    spur_pct  = 0;
  bit    chk_en    = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0010_0093;
      32'h0000_0004: mem_word = 32'h0020_0113;
      32'h0000_0008: mem_word = 32'h0030_0193;
      default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic mem_drive();
    if (!mem_hold && pend.size() > 0 && cyc >= pend[0].due &&
        $urandom_range(99) < resp_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else if (pend.size() == 0 && spur_pct > 0 && $urandom_range(99) < spur_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic mem_edge(input logic exp_req);
    if (!rst_n) begin
      if (mem_clear) pend.delete();
    end else begin
      if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (exp_req && imem_ready) pend.push_back('{m_fetch, cyc + mem_lat});
    end
  endtask

  task automatic model_edge(input logic exp_req);
    bit rsp;
    bit acc;
    if (!rst_n) begin
      m_fetch = RESET_PC;
      m_resp  = RESET_PC;
      mq.delete();
      m_out   = 0;
      m_disc  = 0;
      return;
    end
    rsp = imem_rvalid && (m_out > 0);
    acc = exp_req && imem_ready;
    if (redirect_valid) begin
      mq.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      m_resp  = {redirect_pc[31:2], 2'b00};
      if (rsp) m_out--;
      m_disc  = m_out;
    end else begin
      if (mq.size() > 0 && id_ready) void'(mq.pop_front());
      if (rsp) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          mq.push_back('{m_resp, imem_rdata});
          m_resp = m_resp + 32'd4;
        end
      end
      if (acc) begin
        m_out++;
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  // One clock: entered at a falling edge with inputs set, leaves at the next.
  task automatic cycle();
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    if (mem_auto) mem_drive();
    #1;
    exp_req   = rst_n && !redirect_valid && ((m_out + mq.size()) < DEPTH);
    exp_valid = (mq.size() != 0);
    exp_pc    = 32'h0;
    exp_inst  = 32'h0;
    if (exp_valid) begin
      exp_pc   = mq[0].pc;
      exp_inst = mq[0].inst;
    end
    if (chk_en) begin
      check("imem_req",  32'(imem_req), 32'(exp_req));
      check("imem_addr", imem_addr,     m_fetch);
      check("if_valid",  32'(if_valid), 32'(exp_valid));
      check("if_pc",     if_pc,         exp_pc);
      check("if_inst",   if_inst,       exp_inst);
    end
    @(posedge clk);
    mem_edge(exp_req);
    model_edge(exp_req);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (mq.size() == 0 && n < max) begin
      cycle();
      n++;
    end
    check(name, 32'(if_valid), 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        idr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] pcs [3];
    logic [31:0] wrap_exp [3];
    int          got;

    tbl[0] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0010_0093,  1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h0020_0113,  1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'h0010_0093};
    tbl[3] = '{1'b0, 1'b1, 32'h0030_0193,  1'b1, 1'b1, 32'hC, 1'b1, 32'h4, 32'h0020_0113};
    tbl[4] = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'h0030_0193};
    tbl[5] = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    @(negedge clk);

    // Initial reset: state is unknown before it, so nothing is compared yet.
    do_reset(2);
    chk_en = 1'b1;

    // Reset then stream through a zero-wait memory.
    mem_auto = 1'b0;
    for (int i = 0; i < 6; i++) begin
      imem_ready  = tbl[i].ready;
      imem_rvalid = tbl[i].rvalid;
      imem_rdata  = tbl[i].rdata;
      id_ready    = tbl[i].idr;
      #1;
      check($sformatf("tbl%0d_req", i),   32'(imem_req), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d_addr", i),  imem_addr,     tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_pc", i),    if_pc,         tbl[i].e_pc);
      check($sformatf("tbl%0d_inst", i),  if_inst,       tbl[i].e_inst);
      cycle();
    end
    imem_rvalid = 1'b0;
    mem_auto    = 1'b1;

    // Backpressure: queue fills to DEPTH, one pop frees exactly one slot.
    do_reset(1);
    imem_ready = 1'b1; id_ready = 1'b0; mem_lat = 1;
    repeat (8) cycle();
    check("bp_req_off", 32'(imem_req), 32'd0);
    check("bp_head_pc", if_pc,         32'h0);
    id_ready = 1'b1;
    cycle();
    id_ready = 1'b0;
    check("bp_one_pop", if_pc,     32'h4);
    check("bp_req_on",  32'(imem_req), 32'd1);
    check("bp_addr",    imem_addr, 32'h10);
    repeat (3) cycle();
    check("bp_still",   if_pc,     32'h4);

    // Redirect with two unanswered requests (0x8, 0xC) in flight.
    do_reset(1);
    imem_ready = 1'b1; id_ready = 1'b0; mem_hold = 1'b1;
    repeat (4) cycle();
    mem_hold = 1'b0;
    repeat (2) cycle();
    mem_hold = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    #1;
    check("rd_no_req", 32'(imem_req), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    check("rd_addr",   imem_addr,     32'h40);
    check("rd_flush",  32'(if_valid), 32'd0);
    mem_hold = 1'b0; id_ready = 1'b1;
    wait_valid(50, "rd_wait");
    check("rd_pc",     if_pc,   32'h40);
    check("rd_inst",   if_inst, mem_word(32'h40));

    // Redirect coincident with a response and a pop, outstanding = 3.
    do_reset(1);
    imem_ready = 1'b1; id_ready = 1'b0; mem_hold = 1'b1;
    repeat (4) cycle();
    mem_hold = 1'b0;
    cycle();
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    check("co_empty",  32'(if_valid), 32'd0);
    wait_valid(50, "co_wait");
    check("co_pc",     if_pc,   32'h100);
    check("co_inst",   if_inst, mem_word(32'h100));

    // Address wrap at the top of the 32-bit space.
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0; id_ready = 1'b1; imem_ready = 1'b1;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0;
    for (int i = 0; i < 3; i++) pcs[i] = 32'hDEAD_BEEF;
    got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (if_valid) begin
        pcs[got] = if_pc;
        got++;
      end
      cycle();
    end
    for (int i = 0; i < 3; i++) check($sformatf("wrap_pc%0d", i), pcs[i], wrap_exp[i]);

    // Reset in mid-operation with buffered and in-flight fetches.
    do_reset(1);
    imem_ready = 1'b1; id_ready = 1'b0; mem_hold = 1'b1;
    repeat (4) cycle();
    mem_hold = 1'b0;
    repeat (2) cycle();
    mem_hold = 1'b1; mem_clear = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_req_low", 32'(imem_req), 32'd0);
    cycle();
    rst_n = 1'b1; imem_ready = 1'b0; mem_hold = 1'b0;
    check("mr_valid",   32'(if_valid), 32'd0);
    for (int i = 0; i < 20 && pend.size() > 0; i++) cycle();
    check("mr_ignored", 32'(if_valid), 32'd0);
    check("mr_addr",    imem_addr,     RESET_PC);
    mem_clear = 1'b1; imem_ready = 1'b1; id_ready = 1'b1;
    #1;
    check("mr_req",     32'(imem_req), 32'd1);
    wait_valid(50, "mr_wait");
    check("mr_pc",      if_pc,   RESET_PC);

    // Randomized traffic against the reference model.
    do_reset(1);
    resp_pct = 75; spur_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(199) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = $urandom;
      imem_ready     = ($urandom_range(3) != 0);
      id_ready       = ($urandom_range(2) != 0);
      mem_lat        = 1 + $urandom_range(2);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
